// File: rtl/mem_stage_lsu_pkg.sv
// Shared pipeline constants plus the LSU's access-size and state types.
// funct3 encodings follow the RISC-V load/store opcodes.
package common;

  localparam int OPERAND_WIDTH         = 32;
  localparam int PROGRAM_ADDRESS_WIDTH = 32;

  typedef enum logic [1:0] {BYTE, HALF, WORD, DWORD} mem_size_e;
  typedef enum logic [1:0] {IDLE, REQ, WAIT} lsu_state_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;

endpackage

// File: rtl/mem_stage_lsu_align.sv
// Combinational lane logic: byte enables, store replication, alignment and
// funct3 legality checks, and load extraction with sign/zero extension.
module lsu_align
  import common::*;
#(
  parameter int XLEN = OPERAND_WIDTH,
  localparam int NB = XLEN / 8,
  localparam int OFFW = $clog2(NB)
) (
  input  logic [OFFW-1:0] offset,
  input  logic [2:0]      funct3,
  input  logic            is_store,
  input  logic [XLEN-1:0] store_data,
  input  logic [XLEN-1:0] rdata,
  output logic [NB-1:0]   be,
  output logic [XLEN-1:0] wdata,
  output logic            exc,
  output logic [XLEN-1:0] load_data
);

  mem_size_e       size;
  int              nbytes;
  int              off_i;
  logic            illegal;
  logic [XLEN-1:0] shifted;

  always_comb begin
    size    = mem_size_e'(funct3[1:0]);
    nbytes  = 1 << funct3[1:0];
    off_i   = int'(offset);
    illegal = 1'b0;
    case (funct3)
      F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU: illegal = 1'b0;
      F3_LD, F3_LWU:                       illegal = (XLEN != 64);
      default:                             illegal = 1'b1;
    endcase
    // Stores have no unsigned variants.
    if (is_store && funct3[2]) illegal = 1'b1;
    exc = illegal || ((off_i % nbytes) != 0);

    for (int i = 0; i < NB; i++) begin
      be[i]             = (i >= off_i) && (i < off_i + nbytes);
      wdata[i*8 +: 8]   = store_data[(i % nbytes)*8 +: 8];
    end

    shifted = rdata >> (off_i * 8);
    case (size)
      BYTE:    load_data = funct3[2] ? XLEN'(shifted[7:0])  : XLEN'($signed(shifted[7:0]));
      HALF:    load_data = funct3[2] ? XLEN'(shifted[15:0]) : XLEN'($signed(shifted[15:0]));
      WORD:    load_data = funct3[2] ? XLEN'(shifted[31:0]) : XLEN'($signed(shifted[31:0]));
      default: load_data = shifted;
    endcase
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM stage with a single-outstanding valid/ready data-memory port; owns the
// MEM/WB register and stalls upstream via in_ready while an access is in flight.
module mem_stage_lsu
  import common::*;
#(
  parameter int XLEN       = OPERAND_WIDTH,
  parameter int ADDR_WIDTH = PROGRAM_ADDRESS_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [XLEN-1:0]       alu_result,
  input  logic [XLEN-1:0]       rs2_data,
  input  logic [2:0]            funct3,
  input  logic [4:0]            reg_rd,
  input  logic                  ctrl_mem_read,
  input  logic                  ctrl_mem_write,
  input  logic                  ctrl_mem_to_reg,
  input  logic                  ctrl_reg_write,
  output logic                  dmem_req_valid,
  input  logic                  dmem_req_ready,
  output logic                  dmem_we,
  output logic [ADDR_WIDTH-1:0] dmem_addr,
  output logic [XLEN-1:0]       dmem_wdata,
  output logic [XLEN/8-1:0]     dmem_be,
  input  logic                  dmem_rsp_valid,
  input  logic [XLEN-1:0]       dmem_rdata,
  output logic                  wb_valid,
  output logic [4:0]            wb_reg_rd,
  output logic                  wb_ctrl_reg_write,
  output logic                  wb_ctrl_mem_to_reg,
  output logic [XLEN-1:0]       wb_alu_result,
  output logic [XLEN-1:0]       wb_mem_data,
  output logic                  wb_exc_misaligned,
  output logic [1:0]            dbg_state
);

  localparam int NB   = XLEN / 8;
  localparam int OFFW = $clog2(NB);

  // Handshake: a request transfers on the rising edge where dmem_req_valid and
  // dmem_req_ready are both high; fields hold until then. Upstream transfers on
  // in_valid & in_ready.
  lsu_state_e            state_q, state_d;
  logic                  req_valid_q, req_valid_d, we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [XLEN-1:0]       wdata_q, wdata_d, alu_q, alu_d;
  logic [NB-1:0]         be_q, be_d;
  logic [2:0]            f3_q, f3_d;
  logic [OFFW-1:0]       off_q, off_d;
  logic [4:0]            rd_q, rd_d, wb_rd_q, wb_rd_d;
  logic                  rw_q, rw_d, m2r_q, m2r_d;
  logic                  wb_valid_q, wb_valid_d, wb_rw_q, wb_rw_d;
  logic                  wb_m2r_q, wb_m2r_d, wb_exc_q, wb_exc_d;
  logic [XLEN-1:0]       wb_alu_q, wb_alu_d, wb_mem_q, wb_mem_d;

  logic                  idle, is_mem, mem_exc, al_exc;
  logic [OFFW-1:0]       al_off;
  logic [2:0]            al_f3;
  logic                  al_store;
  logic [NB-1:0]         al_be;
  logic [XLEN-1:0]       al_wdata, al_load;
  logic [ADDR_WIDTH-1:0] aligned_addr;

  assign idle     = (state_q == IDLE);
  assign in_ready = idle;
  assign is_mem   = ctrl_mem_read | ctrl_mem_write;
  assign mem_exc  = is_mem & al_exc;
  // While busy the aligner sees the latched access so load extraction uses it.
  assign al_off   = idle ? alu_result[OFFW-1:0] : off_q;
  assign al_f3    = idle ? funct3 : f3_q;
  assign al_store = idle ? ctrl_mem_write : we_q;

  always_comb begin
    aligned_addr           = ADDR_WIDTH'(alu_result);
    aligned_addr[OFFW-1:0] = '0;
  end

  lsu_align #(.XLEN(XLEN)) u_align (
    .offset     (al_off),
    .funct3     (al_f3),
    .is_store   (al_store),
    .store_data (rs2_data),
    .rdata      (dmem_rdata),
    .be         (al_be),
    .wdata      (al_wdata),
    .exc        (al_exc),
    .load_data  (al_load)
  );

  always_comb begin
    state_d = state_q;  req_valid_d = req_valid_q;  we_d = we_q;
    addr_d = addr_q;    wdata_d = wdata_q;  be_d = be_q;  f3_d = f3_q;
    off_d = off_q;      rd_d = rd_q;  rw_d = rw_q;  m2r_d = m2r_q;  alu_d = alu_q;
    wb_valid_d = 1'b0;  wb_rd_d = wb_rd_q;  wb_rw_d = wb_rw_q;  wb_m2r_d = wb_m2r_q;
    wb_alu_d = wb_alu_q;  wb_mem_d = wb_mem_q;  wb_exc_d = wb_exc_q;
    case (state_q)
      IDLE: if (in_valid) begin
        if (is_mem && !al_exc) begin
          state_d = REQ;  req_valid_d = 1'b1;  we_d = ctrl_mem_write;
          addr_d = aligned_addr;  wdata_d = al_wdata;  be_d = al_be;
          f3_d = funct3;  off_d = alu_result[OFFW-1:0];  rd_d = reg_rd;
          rw_d = ctrl_reg_write;  m2r_d = ctrl_mem_to_reg;  alu_d = alu_result;
        end else begin
          wb_valid_d = 1'b1;  wb_rd_d = reg_rd;  wb_rw_d = ctrl_reg_write & ~mem_exc;
          wb_m2r_d = ctrl_mem_to_reg;  wb_alu_d = alu_result;  wb_mem_d = '0;
          wb_exc_d = mem_exc;
        end
      end
      REQ: if (dmem_req_ready) begin
        req_valid_d = 1'b0;
        if (we_q) begin
          state_d = IDLE;  wb_valid_d = 1'b1;  wb_rd_d = rd_q;  wb_rw_d = rw_q;
          wb_m2r_d = m2r_q;  wb_alu_d = alu_q;  wb_mem_d = '0;  wb_exc_d = 1'b0;
        end else begin
          state_d = WAIT;
        end
      end
      WAIT: if (dmem_rsp_valid) begin
        state_d = IDLE;  wb_valid_d = 1'b1;  wb_rd_d = rd_q;  wb_rw_d = rw_q;
        wb_m2r_d = m2r_q;  wb_alu_d = alu_q;  wb_mem_d = al_load;  wb_exc_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;  req_valid_q <= 1'b0;  we_q <= 1'b0;  addr_q <= '0;
      wdata_q <= '0;  be_q <= '0;  f3_q <= '0;  off_q <= '0;  rd_q <= '0;
      rw_q <= 1'b0;  m2r_q <= 1'b0;  alu_q <= '0;
      wb_valid_q <= 1'b0;  wb_rd_q <= '0;  wb_rw_q <= 1'b0;  wb_m2r_q <= 1'b0;
      wb_alu_q <= '0;  wb_mem_q <= '0;  wb_exc_q <= 1'b0;
    end else begin
      state_q <= state_d;  req_valid_q <= req_valid_d;  we_q <= we_d;  addr_q <= addr_d;
      wdata_q <= wdata_d;  be_q <= be_d;  f3_q <= f3_d;  off_q <= off_d;  rd_q <= rd_d;
      rw_q <= rw_d;  m2r_q <= m2r_d;  alu_q <= alu_d;
      wb_valid_q <= wb_valid_d;  wb_rd_q <= wb_rd_d;  wb_rw_q <= wb_rw_d;
      wb_m2r_q <= wb_m2r_d;  wb_alu_q <= wb_alu_d;  wb_mem_q <= wb_mem_d;
      wb_exc_q <= wb_exc_d;
    end
  end

  assign dmem_req_valid     = req_valid_q;
  assign dmem_we            = we_q;
  assign dmem_addr          = addr_q;
  assign dmem_wdata         = wdata_q;
  assign dmem_be            = be_q;
  assign wb_valid           = wb_valid_q;
  assign wb_reg_rd          = wb_rd_q;
  assign wb_ctrl_reg_write  = wb_rw_q;
  assign wb_ctrl_mem_to_reg = wb_m2r_q;
  assign wb_alu_result      = wb_alu_q;
  assign wb_mem_data        = wb_mem_q;
  assign wb_exc_misaligned  = wb_exc_q;
  assign dbg_state          = state_q;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Bench for mem_stage_lsu at XLEN=32: directed cases plus randomized ops
// scored against an arithmetic model of the load/store rules.
module tb_mem_stage_lsu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready;
  logic [31:0] alu_result, rs2_data;
  logic [2:0]  funct3;
  logic [4:0]  reg_rd;
  logic        ctrl_mem_read, ctrl_mem_write, ctrl_mem_to_reg, ctrl_reg_write;
  logic        dmem_req_valid, dmem_req_ready, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_be;
  logic        dmem_rsp_valid;
  logic        wb_valid, wb_ctrl_reg_write, wb_ctrl_mem_to_reg, wb_exc_misaligned;
  logic [4:0]  wb_reg_rd;
  logic [31:0] wb_alu_result, wb_mem_data;
  logic [1:0]  dbg_state;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  mem_stage_lsu dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .alu_result(alu_result), .rs2_data(rs2_data), .funct3(funct3), .reg_rd(reg_rd),
    .ctrl_mem_read(ctrl_mem_read), .ctrl_mem_write(ctrl_mem_write),
    .ctrl_mem_to_reg(ctrl_mem_to_reg), .ctrl_reg_write(ctrl_reg_write),
    .dmem_req_valid(dmem_req_valid), .dmem_req_ready(dmem_req_ready), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_be(dmem_be),
    .dmem_rsp_valid(dmem_rsp_valid), .dmem_rdata(dmem_rdata),
    .wb_valid(wb_valid), .wb_reg_rd(wb_reg_rd), .wb_ctrl_reg_write(wb_ctrl_reg_write),
    .wb_ctrl_mem_to_reg(wb_ctrl_mem_to_reg), .wb_alu_result(wb_alu_result),
    .wb_mem_data(wb_mem_data), .wb_exc_misaligned(wb_exc_misaligned), .dbg_state(dbg_state)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic model_exc(input logic ld, input logic st, input logic [2:0] f3,
                                     input logic [31:0] a);
    int  n;
    logic legal;
    if (!(ld || st)) return 1'b0;
    legal = (f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5) && !(st && f3 >= 4);
    n = 1 << (f3 % 4);
    return !legal || ((a % n) != 0);
  endfunction

  function automatic logic [3:0] model_be(input logic [2:0] f3, input logic [31:0] a);
    int n;
    n = 1 << (f3 % 4);
    return 4'(((1 << n) - 1) << (a % 4));
  endfunction

  function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] v);
    case (f3 % 4)
      0:       return v[7:0] * 32'h0101_0101;
      1:       return v[15:0] * 32'h0001_0001;
      default: return v;
    endcase
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] rd);
    logic [31:0] sh, v;
    sh = rd >> ((a % 4) * 8);
    case (f3)
      0:       begin v = sh & 32'hFF;   if (v >= 32'h80)   v = v | 32'hFFFF_FF00; end
      4:       v = sh & 32'hFF;
      1:       begin v = sh & 32'hFFFF; if (v >= 32'h8000) v = v | 32'hFFFF_0000; end
      5:       v = sh & 32'hFFFF;
      default: v = sh;
    endcase
    return v;
  endfunction

  task automatic check_wb(input string tag, input logic [4:0] dst, input logic rw,
                          input logic m2r, input logic [31:0] a, input logic exc);
    check({tag, "_wb_valid"}, wb_valid, 1'b1);
    check({tag, "_wb_rd"}, wb_reg_rd, dst);
    check({tag, "_wb_rw"}, wb_ctrl_reg_write, rw & ~exc);
    check({tag, "_wb_m2r"}, wb_ctrl_mem_to_reg, m2r);
    check({tag, "_wb_alu"}, wb_alu_result, a);
    check({tag, "_wb_exc"}, wb_exc_misaligned, exc);
    if (exp_q.size() == 0) check({tag, "_wb_queue_empty"}, 1'b1, 1'b0);
    else check({tag, "_wb_mem"}, wb_mem_data, exp_q.pop_front());
  endtask

  // One instruction from accept to completion with a scripted memory.
  task automatic run_op(input string tag, input logic ld, input logic st, input logic m2r,
                        input logic rw, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] rs2, input logic [4:0] dst, input int req_dly,
                        input int rsp_dly, input logic [31:0] rdata, input logic spurious);
    logic exc, do_req;
    exc    = model_exc(ld, st, f3, a);
    do_req = (ld || st) && !exc;
    exp_q.push_back((ld && do_req) ? model_load(f3, a, rdata) : 32'h0);
    @(negedge clk);
    check({tag, "_in_ready_idle"}, in_ready, 1'b1);
    in_valid = 1'b1;  alu_result = a;  rs2_data = rs2;  funct3 = f3;  reg_rd = dst;
    ctrl_mem_read = ld;  ctrl_mem_write = st;  ctrl_mem_to_reg = m2r;  ctrl_reg_write = rw;
    @(negedge clk);
    in_valid = 1'b0;  alu_result = $urandom;  rs2_data = $urandom;
    if (!do_req) begin
      check({tag, "_no_req"}, dmem_req_valid, 1'b0);
      check_wb(tag, dst, rw, m2r, a, exc);
    end else begin
      check({tag, "_req_valid"}, dmem_req_valid, 1'b1);
      check({tag, "_in_ready_busy"}, in_ready, 1'b0);
      check({tag, "_we"}, dmem_we, st);
      check({tag, "_addr"}, dmem_addr, a & 32'hFFFF_FFFC);
      check({tag, "_be"}, dmem_be, model_be(f3, a));
      if (st) check({tag, "_wdata"}, dmem_wdata, model_wdata(f3, rs2));
      for (int k = 0; k < req_dly; k++) begin
        if (spurious && k == 0) begin dmem_rsp_valid = 1'b1; dmem_rdata = $urandom; end
        @(negedge clk);
        dmem_rsp_valid = 1'b0;
        check({tag, "_hold_valid"}, dmem_req_valid, 1'b1);
        check({tag, "_hold_addr"}, dmem_addr, a & 32'hFFFF_FFFC);
        check({tag, "_hold_be"}, dmem_be, model_be(f3, a));
        if (st) check({tag, "_hold_wdata"}, dmem_wdata, model_wdata(f3, rs2));
        check({tag, "_hold_no_wb"}, wb_valid, 1'b0);
        check({tag, "_hold_stall"}, in_ready, 1'b0);
      end
      dmem_req_ready = 1'b1;
      @(negedge clk);
      dmem_req_ready = 1'b0;
      check({tag, "_req_drop"}, dmem_req_valid, 1'b0);
      if (st) begin
        check_wb(tag, dst, rw, m2r, a, 1'b0);
      end else begin
        for (int k = 0; k < rsp_dly; k++) begin
          check({tag, "_wait_no_wb"}, wb_valid, 1'b0);
          check({tag, "_wait_stall"}, in_ready, 1'b0);
          @(negedge clk);
        end
        check({tag, "_pre_rsp_no_wb"}, wb_valid, 1'b0);
        dmem_rsp_valid = 1'b1;  dmem_rdata = rdata;
        @(negedge clk);
        dmem_rsp_valid = 1'b0;  dmem_rdata = $urandom;
        check_wb(tag, dst, rw, m2r, a, 1'b0);
      end
    end
    @(negedge clk);
    check({tag, "_single_pulse"}, wb_valid, 1'b0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_state"}, dbg_state, 2'd0);
    check({tag, "_in_ready"}, in_ready, 1'b1);
    check({tag, "_req_valid"}, dmem_req_valid, 1'b0);
    check({tag, "_dmem_fields"}, {dmem_we, dmem_be, dmem_addr, dmem_wdata}, 69'h0);
    check({tag, "_wb_ctl"}, {wb_valid, wb_reg_rd, wb_ctrl_reg_write, wb_ctrl_mem_to_reg,
                             wb_exc_misaligned}, 9'h0);
    check({tag, "_wb_alu"}, wb_alu_result, 32'h0);
    check({tag, "_wb_mem"}, wb_mem_data, 32'h0);
  endtask

  initial begin
    rst_n = 1'b0;  in_valid = 1'b0;  alu_result = '0;  rs2_data = '0;  funct3 = '0;
    reg_rd = '0;  ctrl_mem_read = 1'b0;  ctrl_mem_write = 1'b0;  ctrl_mem_to_reg = 1'b0;
    ctrl_reg_write = 1'b0;  dmem_req_ready = 1'b0;  dmem_rsp_valid = 1'b0;  dmem_rdata = '0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;

    run_op("add",  0, 0, 0, 1, 3'b000, 32'h1234, 32'h0, 5'd5, 0, 0, 32'h0, 0);
    run_op("sb",   0, 1, 0, 0, 3'b000, 32'h1003, 32'hAABBCCDD, 5'd0, 3, 0, 32'h0, 0);
    run_op("lb",   1, 0, 1, 1, 3'b000, 32'h2002, 32'h0, 5'd7, 0, 0, 32'h0080_0000, 0);
    run_op("lbu",  1, 0, 1, 1, 3'b100, 32'h2002, 32'h0, 5'd7, 0, 0, 32'h0080_0000, 0);
    run_op("lh_mis", 1, 0, 1, 1, 3'b001, 32'h2001, 32'h0, 5'd9, 0, 0, 32'h0, 0);
    run_op("lw_slow", 1, 0, 1, 1, 3'b010, 32'h3000, 32'h0, 5'd3, 2, 5, 32'hDEADBEEF, 1);
    run_op("sh",   0, 1, 0, 0, 3'b001, 32'h0102, 32'h1234_5678, 5'd0, 1, 0, 32'h0, 0);
    run_op("sbu_ill", 0, 1, 0, 0, 3'b100, 32'h0100, 32'h55, 5'd1, 0, 0, 32'h0, 0);
    run_op("lhu",  1, 0, 1, 1, 3'b101, 32'h0402, 32'h0, 5'd4, 0, 1, 32'h8001_7FFF, 0);
    run_op("ld_ill", 1, 0, 1, 1, 3'b011, 32'h0400, 32'h0, 5'd4, 0, 0, 32'h0, 0);

    for (int i = 0; i < 60; i++) begin
      int          kind;
      logic        ld, st;
      logic [2:0]  f3;
      logic [31:0] a;
      kind = $urandom_range(0, 2);
      ld = (kind == 1);  st = (kind == 2);
      f3 = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 2) != 0) f3 = (st ? 3'($urandom_range(0, 2)) : f3);
      a = $urandom_range(0, 32'hFFFF);
      run_op($sformatf("rnd%0d", i), ld, st, 1'($urandom), 1'($urandom), f3, a, $urandom,
             5'($urandom), $urandom_range(0, 3), $urandom_range(0, 3), $urandom,
             1'($urandom));
    end

    // Reset while waiting on a load; the stale response must be dropped.
    @(negedge clk);
    in_valid = 1'b1;  alu_result = 32'h40;  funct3 = 3'b010;  reg_rd = 5'd2;
    ctrl_mem_read = 1'b1;  ctrl_mem_write = 1'b0;  ctrl_reg_write = 1'b1;  ctrl_mem_to_reg = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;  ctrl_mem_read = 1'b0;
    check("rst_wait_req", dmem_req_valid, 1'b1);
    dmem_req_ready = 1'b1;
    @(negedge clk);
    dmem_req_ready = 1'b0;
    check("rst_wait_state", dbg_state, 2'd2);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("rst_mid");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    dmem_rsp_valid = 1'b1;  dmem_rdata = 32'hCAFEF00D;
    @(negedge clk);
    dmem_rsp_valid = 1'b0;
    check("late_rsp_no_wb", wb_valid, 1'b0);
    check("late_rsp_idle", in_ready, 1'b1);
    @(negedge clk);
    check("late_rsp_no_wb2", wb_valid, 1'b0);
    check("late_rsp_no_req", dmem_req_valid, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
